// File: rtl/ttt_pkg.sv
// ttt_pkg -- shared definitions for the tic-tac-toe turn controller.
//   state_t      : controller state encoding
//   CELL_*       : 2-bit cell codes stored in the board vector
//   WIN_*        : winner codes
//   WIN_LINES    : the 8 winning lines (rows, columns, diagonals) as cell indices
//   lowest_empty : index of the lowest-numbered empty cell on a board
package ttt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAYER,
        S_P_CHECK,
        S_COMPUTER,
        S_C_CHECK,
        S_DONE
    } state_t;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_PLAYER = 2'b01;
    localparam logic [1:0] WIN_CPU    = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    // Entry 0 is the leftmost group of the concatenation.
    localparam logic [0:NUM_LINES-1][0:2][3:0] WIN_LINES = {
        4'd0, 4'd1, 4'd2,
        4'd3, 4'd4, 4'd5,
        4'd6, 4'd7, 4'd8,
        4'd0, 4'd3, 4'd6,
        4'd1, 4'd4, 4'd7,
        4'd2, 4'd5, 4'd8,
        4'd0, 4'd4, 4'd8,
        4'd2, 4'd4, 4'd6
    };

    // Scans downward so the last hit (lowest index) wins.
    function automatic logic [3:0] lowest_empty(input logic [17:0] b);
        lowest_empty = 4'd0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (b[2*i +: 2] == CELL_EMPTY) begin
                lowest_empty = i[3:0];
            end
        end
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// ttt_win_detect -- purely combinational line/full detection for a 3x3 board.
//   board  in  18  cell i in bits [2i+1:2i]
//   x_win  out 1   some line is all X
//   o_win  out 1   some line is all O
//   full   out 1   no empty cell remains
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    output logic        x_win,
    output logic        o_win,
    output logic        full
);

    logic [NUM_LINES-1:0] x_line;
    logic [NUM_LINES-1:0] o_line;
    logic [NUM_CELLS-1:0] cell_used;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            localparam int C0 = int'(WIN_LINES[gi][0]);
            localparam int C1 = int'(WIN_LINES[gi][1]);
            localparam int C2 = int'(WIN_LINES[gi][2]);
            assign x_line[gi] = (board[2*C0 +: 2] == CELL_X) &&
                                (board[2*C1 +: 2] == CELL_X) &&
                                (board[2*C2 +: 2] == CELL_X);
            assign o_line[gi] = (board[2*C0 +: 2] == CELL_O) &&
                                (board[2*C1 +: 2] == CELL_O) &&
                                (board[2*C2 +: 2] == CELL_O);
        end
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            assign cell_used[gi] = (board[2*gi +: 2] != CELL_EMPTY);
        end
    endgenerate

    assign x_win = |x_line;
    assign o_win = |o_line;
    assign full  = &cell_used;

endmodule

// File: rtl/ttt_turn_ctrl.sv
// ttt_turn_ctrl -- turn sequencing for player (X) versus computer (O).
// Optional feature: define TTT_CPU_DELAY_EN to make the computer wait
// CPU_DELAY board_clk cycles in COMPUTER before placing its mark.
//   board_clk                  in   clock
//   reset                      in   asynchronous active-high reset
//   btn_up/down/l/r/sel        in   single-cycle button pulses
//   board                      out  18-bit board, cell i at [2i+1:2i]
//   cursor                     out  selected cell 0..8
//   q_idle/q_player/q_computer/q_done  out  one-hot visible state
//   winner                     out  00 none, 01 X, 10 O, 11 draw
//   legal_move, illegal_move   out  one-cycle selection outcome pulses
module ttt_turn_ctrl
    import ttt_pkg::*;
#(
    parameter logic [26:0] CPU_DELAY = 27'd50_000_000
) (
    input  logic        board_clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_sel,
    output logic [17:0] board,
    output logic [3:0]  cursor,
    output logic        q_idle,
    output logic        q_player,
    output logic        q_computer,
    output logic        q_done,
    output logic [1:0]  winner,
    output logic        legal_move,
    output logic        illegal_move
);

    state_t      state_reg,   state_next;
    logic [17:0] board_reg,   board_next;
    logic [3:0]  cursor_reg,  cursor_next;
    logic [1:0]  winner_reg,  winner_next;
    logic        legal_reg,   legal_next;
    logic        illegal_reg, illegal_next;

    logic        x_win, o_win, full;
    logic        cpu_go;
    logic [1:0]  cur_cell;
    logic        at_top, at_bottom, at_left, at_right;

    ttt_win_detect u_win_detect (
        .board (board_reg),
        .x_win (x_win),
        .o_win (o_win),
        .full  (full)
    );

`ifdef TTT_CPU_DELAY_EN
    logic [26:0] delay_cnt_reg, delay_cnt_next;

    // Written on the CPU_DELAY-th cycle in COMPUTER; 0 or 1 means no wait.
    assign cpu_go = ((delay_cnt_reg + 27'd1) >= CPU_DELAY);

    always_comb begin
        delay_cnt_next = '0;
        if (state_reg == S_COMPUTER && !cpu_go) begin
            delay_cnt_next = delay_cnt_reg + 27'd1;
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            delay_cnt_reg <= '0;
        end else begin
            delay_cnt_reg <= delay_cnt_next;
        end
    end
`else
    assign cpu_go = 1'b1;
`endif

    assign cur_cell  = board_reg[{cursor_reg, 1'b0} +: 2];
    assign at_top    = (cursor_reg < 4'd3);
    assign at_bottom = (cursor_reg > 4'd5);
    assign at_left   = (cursor_reg == 4'd0) || (cursor_reg == 4'd3) || (cursor_reg == 4'd6);
    assign at_right  = (cursor_reg == 4'd2) || (cursor_reg == 4'd5) || (cursor_reg == 4'd8);

    always_comb begin
        state_next   = state_reg;
        board_next   = board_reg;
        cursor_next  = cursor_reg;
        winner_next  = winner_reg;
        legal_next   = 1'b0;
        illegal_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (btn_sel) begin
                    board_next  = '0;
                    cursor_next = 4'd4;
                    winner_next = WIN_NONE;
                    state_next  = S_PLAYER;
                end
            end
            S_PLAYER: begin
                // A blocked move still consumes the press: lower-priority
                // buttons in the same cycle are not considered.
                if (btn_sel) begin
                    if (cur_cell == CELL_EMPTY) begin
                        board_next[{cursor_reg, 1'b0} +: 2] = CELL_X;
                        legal_next = 1'b1;
                        state_next = S_P_CHECK;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end else if (btn_up) begin
                    if (!at_top) cursor_next = cursor_reg - 4'd3;
                end else if (btn_down) begin
                    if (!at_bottom) cursor_next = cursor_reg + 4'd3;
                end else if (btn_l) begin
                    if (!at_left) cursor_next = cursor_reg - 4'd1;
                end else if (btn_r) begin
                    if (!at_right) cursor_next = cursor_reg + 4'd1;
                end
            end
            S_P_CHECK: begin
                if (x_win) begin
                    winner_next = WIN_PLAYER;
                    state_next  = S_DONE;
                end else if (full) begin
                    winner_next = WIN_DRAW;
                    state_next  = S_DONE;
                end else begin
                    state_next  = S_COMPUTER;
                end
            end
            S_COMPUTER: begin
                // Reached only from a non-full board, so an empty cell exists.
                if (cpu_go) begin
                    board_next[{lowest_empty(board_reg), 1'b0} +: 2] = CELL_O;
                    state_next = S_C_CHECK;
                end
            end
            S_C_CHECK: begin
                if (o_win) begin
                    winner_next = WIN_CPU;
                    state_next  = S_DONE;
                end else if (full) begin
                    winner_next = WIN_DRAW;
                    state_next  = S_DONE;
                end else begin
                    state_next  = S_PLAYER;
                end
            end
            S_DONE: begin
                if (btn_sel) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            board_reg   <= '0;
            cursor_reg  <= 4'd4;
            winner_reg  <= WIN_NONE;
            legal_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            board_reg   <= board_next;
            cursor_reg  <= cursor_next;
            winner_reg  <= winner_next;
            legal_reg   <= legal_next;
            illegal_reg <= illegal_next;
        end
    end

    assign board        = board_reg;
    assign cursor       = cursor_reg;
    assign winner       = winner_reg;
    assign legal_move   = legal_reg;
    assign illegal_move = illegal_reg;
    assign q_idle       = (state_reg == S_IDLE);
    assign q_player     = (state_reg == S_PLAYER)   || (state_reg == S_P_CHECK);
    assign q_computer   = (state_reg == S_COMPUTER) || (state_reg == S_C_CHECK);
    assign q_done       = (state_reg == S_DONE);

endmodule
